trans_ingress_arbiter: RTL

//  Round-robin scheduler that shares the single transaction validator among N_PORTS ingress streams.

---
 rtl/trans_ingress_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/trans_ingress_arbiter.sv
// Round-robin arbiter sharing one transaction validator among N_PORTS ingress streams.
// Holds one transaction toward the validator until ack, or drops it after TIMEOUT cycles.
module trans_ingress_arbiter #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*DATA_W-1:0]   req_data_i,
  input  logic [N_PORTS-1:0]          req_valid_i,
  output logic [N_PORTS-1:0]          req_ready_o,
  output logic [DATA_W-1:0]           val_data_o,
  output logic                        val_valid_o,
  input  logic                        val_ack_i,
  output logic [N_PORTS-1:0]          grant_o,
  output logic                        busy_o,
  output logic                        timeout_o,
  output logic [CNT_W-1:0]            fwd_count_o,
  output logic [CNT_W-1:0]            drop_count_o
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT) + 1;

  localparam logic [0:0]    IDLE      = 1'b0;
  localparam logic [0:0]    ISSUE     = 1'b1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_MAX  = {WW{1'b1}};
  localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS - 1);

  logic [0:0]          state, state_n;
  logic [PW-1:0]       rr_last, rr_last_n;
  logic [WW-1:0]       wait_cnt, wait_cnt_n;
  logic [DATA_W-1:0]   data_n;
  logic                valid_n, busy_n, timeout_n;
  logic [N_PORTS-1:0]  grant_n;
  logic [CNT_W-1:0]    fwd_n, drop_n;

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand;
  logic [N_PORTS-1:0]  win_onehot;
  logic [DATA_W-1:0]   win_data;

  // Round-robin search starting just after the last served port
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      cand = PW'((32'(rr_last) + i) % N_PORTS);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot  = win_found ? (N_PORTS'(1) << win_idx) : '0;
  assign win_data    = req_data_i[32'(win_idx)*DATA_W +: DATA_W];
  assign req_ready_o = (state == IDLE && !rst) ? win_onehot : '0;

  always_comb begin
    state_n    = state;
    rr_last_n  = rr_last;
    wait_cnt_n = wait_cnt;
    data_n     = val_data_o;
    valid_n    = val_valid_o;
    grant_n    = grant_o;
    timeout_n  = 1'b0;
    fwd_n      = fwd_count_o;
    drop_n     = drop_count_o;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n    = ISSUE;
          data_n     = win_data;
          valid_n    = 1'b1;
          grant_n    = win_onehot;
          rr_last_n  = win_idx;
          wait_cnt_n = '0;
        end
      end
      ISSUE: begin
        wait_cnt_n = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);
        // Ack beats a coincident timeout
        if (val_ack_i) begin
          state_n = IDLE;
          valid_n = 1'b0;
          grant_n = '0;
          fwd_n   = fwd_count_o + CNT_W'(1);
        end else if (wait_cnt == WAIT_LAST) begin
          state_n   = IDLE;
          valid_n   = 1'b0;
          grant_n   = '0;
          timeout_n = 1'b1;
          drop_n    = drop_count_o + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_last      <= LAST_PORT;
      wait_cnt     <= '0;
      val_data_o   <= '0;
      val_valid_o  <= 1'b0;
      grant_o      <= '0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
      fwd_count_o  <= '0;
      drop_count_o <= '0;
    end else begin
      state        <= state_n;
      rr_last      <= rr_last_n;
      wait_cnt     <= wait_cnt_n;
      val_data_o   <= data_n;
      val_valid_o  <= valid_n;
      grant_o      <= grant_n;
      busy_o       <= busy_n;
      timeout_o    <= timeout_n;
      fwd_count_o  <= fwd_n;
      drop_count_o <= drop_n;
    end
  end

endmodule
